// File: rtl/pmem_pkg.sv
// ----------------------------------------------------------------------------
// pmem_pkg
// Shared definitions for the pmem responder slice:
//   - request size encodings (SZ_B / SZ_H / SZ_W; 2'd3 is illegal)
//   - responder FSM state type
//   - default base byte address of RAM word 0
//   - lane_mask(): byte-enable mask for a given size and byte lane
// ----------------------------------------------------------------------------
package pmem_pkg;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam logic [31:0] PMEM_BASE_ADDR = 32'h8000_0000;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_RESP = 2'd2
   } state_e;

   // Byte-enable mask for an access of the given size starting at byte lane.
   // Lanes that would spill past byte 3 are dropped; such accesses are
   // flagged as misaligned elsewhere and never reach the RAM.
   function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                            input logic [1:0] lane);
      logic [3:0] base;
      case (size)
         SZ_B:    base = 4'b0001;
         SZ_H:    base = 4'b0011;
         SZ_W:    base = 4'b1111;
         default: base = 4'b0000;
      endcase
      return base << lane;
   endfunction

endpackage

// File: rtl/pmem_if.sv
// ----------------------------------------------------------------------------
// pmem_if
// Request/response bundle between a memory requester (core LSU/IFU) and the
// pmem responder.
//   req_valid/req_ready : request handshake
//   req_wen             : 1 = write, 0 = read
//   req_addr            : byte address
//   req_size            : 0 byte, 1 half, 2 word, 3 illegal
//   req_wdata           : LSB-aligned write data
//   rsp_valid/rsp_ready : response handshake
//   rsp_rdata           : LSB-aligned, zero-extended read data (0 for writes)
//   rsp_err             : access fault
// Modports: master = requester side, slave = responder side.
// ----------------------------------------------------------------------------
interface pmem_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_wen;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;

   modport master (
      output req_valid, req_wen, req_addr, req_size, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_wen, req_addr, req_size, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/pmem_lane_align.sv
// ----------------------------------------------------------------------------
// pmem_lane_align
// Combinational byte-lane steering for the pmem responder.
//   size_i     : access size (SZ_B / SZ_H / SZ_W, 2'd3 illegal)
//   lane_i     : byte lane = addr[1:0]
//   wdata_i    : LSB-aligned write data
//   rword_i    : full RAM word at the addressed index
//   wmask_o    : byte-enable mask for the RAM write
//   wdata_o    : write data moved up to its byte lane
//   rdata_o    : addressed bytes moved down to bit 0, zero-extended
//   misalign_o : access straddles a word boundary or uses the illegal size
// ----------------------------------------------------------------------------
module pmem_lane_align
   import pmem_pkg::*;
(
   input  logic [1:0]  size_i,
   input  logic [1:0]  lane_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] rword_i,
   output logic [3:0]  wmask_o,
   output logic [31:0] wdata_o,
   output logic [31:0] rdata_o,
   output logic        misalign_o
);

   logic [31:0] rshift_s;

   // Lane steering, read extraction and alignment check.
   always_comb begin
      wmask_o  = lane_mask(size_i, lane_i);
      wdata_o  = wdata_i << {lane_i, 3'b000};
      rshift_s = rword_i >> {lane_i, 3'b000};

      case (size_i)
         SZ_B: begin
            misalign_o = 1'b0;
            rdata_o    = {24'h00_0000, rshift_s[7:0]};
         end
         SZ_H: begin
            // A half at lane 1 or 2 still fits inside the word.
            misalign_o = (lane_i == 2'd3);
            rdata_o    = {16'h0000, rshift_s[15:0]};
         end
         SZ_W: begin
            misalign_o = (lane_i != 2'd0);
            rdata_o    = rshift_s;
         end
         default: begin
            misalign_o = 1'b1;
            rdata_o    = 32'h0000_0000;
         end
      endcase
   end

endmodule

// File: rtl/pmem_responder.sv
// ----------------------------------------------------------------------------
// pmem_responder
// Memory-side far end of the core memory port. Accepts one request at a time,
// waits LATENCY cycles, performs the RAM access, then presents a registered
// response until the requester takes it.
//
// Parameters:
//   BASE_ADDR  : byte address of RAM word 0
//   DEPTH_LOG2 : RAM holds 2**DEPTH_LOG2 32-bit words
//   LATENCY    : 1..15; rsp_valid rises LATENCY+1 cycles after the accept
//
// Ports:
//   clk   : clock
//   reset : synchronous, active-high reset (RAM contents survive it)
//   pmem  : pmem_if.slave request/response bundle
//
// Build option:
//   PMEM_BOUND_CHK_EN : when defined, addresses outside the RAM window give
//                       rsp_err = 1 and never write; when undefined the word
//                       index simply wraps modulo the RAM depth.
// ----------------------------------------------------------------------------
module pmem_responder
   import pmem_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR  = PMEM_BASE_ADDR,
   parameter int          DEPTH_LOG2 = 12,
   parameter int          LATENCY    = 2
) (
   input logic   clk,
   input logic   reset,
   pmem_if.slave pmem
);

   localparam int         DEPTH  = 1 << DEPTH_LOG2;
   localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

   state_e                  state_q, state_d;
   logic [3:0]              cnt_q, cnt_d;
   logic                    wen_q, wen_d;
   logic [31:0]             addr_q, addr_d;
   logic [1:0]              size_q, size_d;
   logic [31:0]             wdata_q, wdata_d;
   logic                    req_ready_q, req_ready_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [31:0]             rsp_rdata_q, rsp_rdata_d;
   logic                    rsp_err_q, rsp_err_d;

   logic [31:0]             mem_q [0:DEPTH-1];

   logic [31:0]             off_s;
   logic [DEPTH_LOG2-1:0]   idx_s;
   logic [31:0]             rword_s;
   logic [3:0]              wmask_s;
   logic [31:0]             wdata_sh_s;
   logic [31:0]             rdata_s;
   logic                    misalign_s;
   logic                    oob_s;
   logic                    fault_s;
   logic                    access_s;
   logic                    do_write_s;
   logic                    off_unused_s;

   // Addressing is always derived from the latched request, so the access
   // performed at the end of WAIT is independent of the live bus.
   assign off_s   = addr_q - BASE_ADDR;
   assign idx_s   = off_s[DEPTH_LOG2+1:2];
   assign rword_s = mem_q[idx_s];

`ifdef PMEM_BOUND_CHK_EN
   // Any set bit above the window means off >= 4*DEPTH; addresses below
   // BASE_ADDR wrap to huge offsets and are caught here as well.
   assign oob_s        = |off_s[31:DEPTH_LOG2+2];
   assign off_unused_s = ^off_s[1:0];
`else
   assign oob_s        = 1'b0;
   assign off_unused_s = ^{off_s[31:DEPTH_LOG2+2], off_s[1:0]};
`endif

   assign fault_s = misalign_s | oob_s;

   pmem_lane_align u_lane_align (
      .size_i     (size_q),
      .lane_i     (addr_q[1:0]),
      .wdata_i    (wdata_q),
      .rword_i    (rword_s),
      .wmask_o    (wmask_s),
      .wdata_o    (wdata_sh_s),
      .rdata_o    (rdata_s),
      .misalign_o (misalign_s)
   );

   // Next-state and next-output logic for the IDLE/WAIT/RESP sequencer.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      wen_d       = wen_q;
      addr_d      = addr_q;
      size_d      = size_q;
      wdata_d     = wdata_q;
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      access_s    = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (pmem.req_valid) begin
               wen_d   = pmem.req_wen;
               addr_d  = pmem.req_addr;
               size_d  = pmem.req_size;
               wdata_d = pmem.req_wdata;
               cnt_d   = LAT_M1;
               state_d = S_WAIT;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               access_s    = 1'b1;
               rsp_err_d   = fault_s;
               rsp_rdata_d = (fault_s || wen_q) ? 32'h0000_0000 : rdata_s;
               state_d     = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            // rsp_valid is raised on the first RESP edge; the handshake is
            // only honoured once it is actually visible to the requester.
            if (rsp_valid_q) begin
               if (pmem.rsp_ready) begin
                  rsp_valid_d = 1'b0;
                  state_d     = S_IDLE;
               end else begin
                  rsp_valid_d = 1'b1;
               end
            end else begin
               rsp_valid_d = 1'b1;
            end
         end
         default: begin
            state_d     = S_IDLE;
            rsp_valid_d = 1'b0;
         end
      endcase

      req_ready_d = (state_d == S_IDLE);
   end

   // A reset on the access edge abandons the write along with the response.
   assign do_write_s = access_s & wen_q & ~fault_s & ~reset;

   // Sequencer, latched request and registered response outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= 4'd0;
         wen_q       <= 1'b0;
         addr_q      <= 32'h0000_0000;
         size_q      <= 2'd0;
         wdata_q     <= 32'h0000_0000;
         req_ready_q <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0000_0000;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wen_q       <= wen_d;
         addr_q      <= addr_d;
         size_q      <= size_d;
         wdata_q     <= wdata_d;
         req_ready_q <= req_ready_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

   // Byte-masked RAM write; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (do_write_s) begin
         for (int b = 0; b < 4; b++) begin
            if (wmask_s[b]) begin
               mem_q[idx_s][8*b +: 8] <= wdata_sh_s[8*b +: 8];
            end
         end
      end
   end

   assign pmem.req_ready = req_ready_q;
   assign pmem.rsp_valid = rsp_valid_q;
   assign pmem.rsp_rdata = rsp_rdata_q;
   assign pmem.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_pmem_responder.sv
// ----------------------------------------------------------------------------
// tb_pmem_responder
// Self-checking bench for pmem_responder (LATENCY = 3). Expected data and
// error flags come from a byte-addressed reference memory that applies the
// access rules directly (byte count, lane fit, window bounds).
// ----------------------------------------------------------------------------
module tb_pmem_responder;
   import pmem_pkg::*;

   localparam int          TB_LAT = 3;
   localparam int          DLOG   = 12;
   localparam int          DEPTH  = 1 << DLOG;
   localparam logic [31:0] BASE   = 32'h8000_0000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   pmem_if bus ();

   pmem_responder #(
      .BASE_ADDR  (BASE),
      .DEPTH_LOG2 (DLOG),
      .LATENCY    (TB_LAT)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .pmem  (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0] bmem [int];

   // Reference: one entry per RAM byte, keyed by wrapped word index*4 + byte.
   function automatic void model_access(input logic wen, input logic [31:0] addr,
                                        input logic [1:0] size, input logic [31:0] wdata,
                                        output logic [31:0] rd, output logic er);
      int          nb;
      int          lane;
      int          wi;
      int          key;
      logic [31:0] off;
      nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : (size == 2'd2) ? 4 : 0;
      lane = int'(addr % 32'd4);
      off  = addr - BASE;
      er   = (nb == 0) || (lane + nb > 4);
`ifdef PMEM_BOUND_CHK_EN
      if (off >= 32'(4 * DEPTH)) er = 1'b1;
`endif
      rd = 32'h0;
      if (!er) begin
         wi = int'((off / 32'd4) % 32'(DEPTH));
         for (int k = 0; k < nb; k++) begin
            key = wi * 4 + lane + k;
            if (wen) bmem[key] = 8'(wdata >> (8 * k));
            else if (bmem.exists(key)) rd = rd | (32'(bmem[key]) << (8 * k));
         end
         if (wen) rd = 32'h0;
      end
   endfunction

   // One complete transaction: request, wait for response, optional
   // backpressure of 'hold' cycles, then handshake.
   task automatic txn(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                      input logic [31:0] wdata, input int hold,
                      output logic [31:0] rdata, output logic err, output int lat);
      int n;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wen   = wen;
      bus.req_addr  = addr;
      bus.req_size  = size;
      bus.req_wdata = wdata;
      bus.rsp_ready = (hold == 0);
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (n >= 50) begin
         n_fail++;
         $display("FAIL accept_timeout: req_ready=%b required 1 within 50 cycles", bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 64) begin
         @(negedge clk);
         lat++;
      end
      rdata = bus.rsp_rdata;
      err   = bus.rsp_err;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rdata || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable: valid=%b rdata=%h req_ready=%b required 1/%h/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.req_ready, rdata);
         end
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rsp_release: valid=%b req_ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
      end
   endtask

   task automatic test_reset;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_wen   = 1'b0;
      bus.req_addr  = 32'h0;
      bus.req_size  = 2'd0;
      bus.req_wdata = 32'h0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b required 0", bus.rsp_valid); end
      n_checks++;
      if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h required 0", bus.rsp_rdata); end
      n_checks++;
      if (bus.rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", bus.rsp_err); end
      n_checks++;
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b required 1", bus.req_ready); end
   endtask

   task automatic test_word_rw;
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat;
      txn(1'b1, BASE + 32'h10, SZ_W, 32'hDEAD_BEEF, 0, rd, er, lat);
      model_access(1'b1, BASE + 32'h10, SZ_W, 32'hDEAD_BEEF, mrd, mer);
      n_checks++;
      if (er !== 1'b0 || rd !== 32'h0) begin n_fail++; $display("FAIL word_write_rsp: err=%b rdata=%h required 0/0", er, rd); end
      n_checks++;
      if (lat != TB_LAT + 1) begin n_fail++; $display("FAIL word_write_latency: got %0d required %0d", lat, TB_LAT + 1); end
      txn(1'b0, BASE + 32'h10, SZ_W, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hDEAD_BEEF || er !== 1'b0) begin n_fail++; $display("FAIL word_read: rdata=%h err=%b required deadbeef/0", rd, er); end
      n_checks++;
      if (lat != TB_LAT + 1) begin n_fail++; $display("FAIL word_read_latency: got %0d required %0d", lat, TB_LAT + 1); end
   endtask

   task automatic test_byte_lanes;
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat;
      txn(1'b1, BASE + 32'h13, SZ_B, 32'h0000_00AB, 0, rd, er, lat);
      model_access(1'b1, BASE + 32'h13, SZ_B, 32'h0000_00AB, mrd, mer);
      n_checks++;
      if (er !== 1'b0) begin n_fail++; $display("FAIL byte_write_err: got %b required 0", er); end
      txn(1'b0, BASE + 32'h10, SZ_W, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 32'hABAD_BEEF) begin n_fail++; $display("FAIL byte_merge_word: got %h required abadbeef", rd); end
      txn(1'b0, BASE + 32'h13, SZ_B, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h0000_00AB || er !== 1'b0) begin n_fail++; $display("FAIL byte_read: rdata=%h err=%b required 000000ab/0", rd, er); end
      txn(1'b0, BASE + 32'h12, SZ_H, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h0000_ABAD) begin n_fail++; $display("FAIL half_read_lane2: got %h required 0000abad", rd); end
   endtask

   task automatic test_backpressure;
      logic [31:0] rd;
      int          n, lat;
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wen   = 1'b0;
      bus.req_addr  = BASE + 32'h10;
      bus.req_size  = SZ_W;
      bus.req_wdata = 32'h0;
      bus.rsp_ready = 1'b0;
      n = 0;
      while (bus.req_ready !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      @(negedge clk);
      // Second request held pending throughout the first response.
      bus.req_addr = BASE + 32'h13;
      bus.req_size = SZ_B;
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat != TB_LAT + 1) begin n_fail++; $display("FAIL bp_latency: got %0d required %0d", lat, TB_LAT + 1); end
      rd = bus.rsp_rdata;
      n_checks++;
      if (rd !== 32'hABAD_BEEF) begin n_fail++; $display("FAIL bp_rdata: got %h required abadbeef", rd); end
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== 32'hABAD_BEEF || bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_stable: valid=%b rdata=%h req_ready=%b required 1/abadbeef/0",
                     bus.rsp_valid, bus.rsp_rdata, bus.req_ready);
         end
         @(negedge clk);
      end
      bus.rsp_ready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: valid=%b req_ready=%b required 0/1", bus.rsp_valid, bus.req_ready);
      end
      @(negedge clk);
      bus.req_valid = 1'b0;
      lat = 0;
      while (bus.rsp_valid !== 1'b1 && lat < 64) begin @(negedge clk); lat++; end
      n_checks++;
      if (lat != TB_LAT + 1 || bus.rsp_rdata !== 32'h0000_00AB) begin
         n_fail++;
         $display("FAIL bp_second: latency=%0d rdata=%h required %0d/000000ab", lat, bus.rsp_rdata, TB_LAT + 1);
      end
      @(negedge clk);
   endtask

   task automatic test_misaligned;
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat;
      txn(1'b1, BASE + 32'h04, SZ_W, 32'h0BAD_F00D, 0, rd, er, lat);
      model_access(1'b1, BASE + 32'h04, SZ_W, 32'h0BAD_F00D, mrd, mer);
      txn(1'b0, BASE + 32'h02, SZ_W, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misalign_word_read: err=%b rdata=%h required 1/0", er, rd); end
      txn(1'b1, BASE + 32'h07, SZ_H, 32'h0000_FFFF, 0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL misalign_half_write: err=%b rdata=%h required 1/0", er, rd); end
      txn(1'b0, BASE + 32'h04, SZ_W, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h0BAD_F00D || er !== 1'b0) begin n_fail++; $display("FAIL misalign_no_update: rdata=%h err=%b required 0badf00d/0", rd, er); end
      txn(1'b0, BASE + 32'h04, 2'd3, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL illegal_size: err=%b rdata=%h required 1/0", er, rd); end
   endtask

   task automatic test_bounds;
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat;
      txn(1'b1, BASE + 32'(4 * (DEPTH - 1)), SZ_W, 32'hCAFE_1234, 0, rd, er, lat);
      model_access(1'b1, BASE + 32'(4 * (DEPTH - 1)), SZ_W, 32'hCAFE_1234, mrd, mer);
      txn(1'b0, 32'h7FFF_FFFC, SZ_W, 32'h0, 0, rd, er, lat);
`ifdef PMEM_BOUND_CHK_EN
      n_checks++;
      if (er !== 1'b1 || rd !== 32'h0) begin n_fail++; $display("FAIL bounds_below_base: err=%b rdata=%h required 1/0", er, rd); end
`else
      n_checks++;
      if (er !== 1'b0 || rd !== 32'hCAFE_1234) begin n_fail++; $display("FAIL bounds_wrap: err=%b rdata=%h required 0/cafe1234", er, rd); end
`endif
   endtask

   task automatic test_reset_mid_wait;
      logic [31:0] rd, mrd;
      logic        er, mer;
      int          lat;
      logic        seen;
      txn(1'b1, BASE + 32'h20, SZ_W, 32'h1122_3344, 0, rd, er, lat);
      model_access(1'b1, BASE + 32'h20, SZ_W, 32'h1122_3344, mrd, mer);
      @(negedge clk);
      bus.req_valid = 1'b1;
      bus.req_wen   = 1'b1;
      bus.req_addr  = BASE + 32'h20;
      bus.req_size  = SZ_W;
      bus.req_wdata = 32'h5566_7788;
      @(negedge clk);
      bus.req_valid = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      n_checks++;
      if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b required 1", bus.req_ready); end
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         if (bus.rsp_valid !== 1'b0) seen = 1'b1;
         @(negedge clk);
      end
      n_checks++;
      if (seen !== 1'b0) begin n_fail++; $display("FAIL midreset_no_rsp: rsp_valid rose=%b required 0", seen); end
      txn(1'b0, BASE + 32'h20, SZ_W, 32'h0, 0, rd, er, lat);
      n_checks++;
      if (rd !== 32'h1122_3344) begin n_fail++; $display("FAIL midreset_old_value: got %h required 11223344", rd); end
   endtask

   task automatic test_random;
      logic [31:0] rd, mrd, addr, wd;
      logic        er, mer, wen;
      logic [1:0]  sz;
      int          lat;
      for (int k = 0; k < 8; k++) begin
         wd = $urandom;
         txn(1'b1, BASE + 32'h100 + 32'(4 * k), SZ_W, wd, 0, rd, er, lat);
         model_access(1'b1, BASE + 32'h100 + 32'(4 * k), SZ_W, wd, mrd, mer);
      end
      for (int t = 0; t < 60; t++) begin
         wen  = 1'($urandom_range(0, 1));
         sz   = 2'($urandom_range(0, 3));
         addr = BASE + 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
         wd   = $urandom;
         txn(wen, addr, sz, wd, int'($urandom_range(0, 2)), rd, er, lat);
         model_access(wen, addr, sz, wd, mrd, mer);
         n_checks++;
         if (rd !== mrd || er !== mer) begin
            n_fail++;
            $display("FAIL rand_rsp: wen=%b addr=%h size=%0d got %h/%b required %h/%b",
                     wen, addr, sz, rd, er, mrd, mer);
         end
         n_checks++;
         if (lat != TB_LAT + 1) begin n_fail++; $display("FAIL rand_latency: got %0d required %0d", lat, TB_LAT + 1); end
      end
   endtask

   initial begin
      test_reset();
      test_word_rw();
      test_byte_lanes();
      test_backpressure();
      test_misaligned();
      test_bounds();
      test_reset_mid_wait();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
